// File: rtl/com_host_link_if.sv
// Host link bundle: host buffer port, processor load/output handshake and result port.
// master = host/processor side, slave = com_host_link.
interface com_host_link_if #(
   parameter int DATA_W = 16,
   parameter int AW     = 10
);
   logic              host_wr_en;
   logic [AW-1:0]     host_addr;
   logic [DATA_W-1:0] host_data;
   logic              go;
   logic              busy;
   logic              data_write_start;
   logic [DATA_W-1:0] com_data_in;
   logic              data_write_done;
   logic              output_write_start;
   logic              output_write_done;
   logic [DATA_W-1:0] com_data_out;
   logic              res_valid;
   logic [10:0]       res_index;
   logic [DATA_W-1:0] res_data;
   logic              run_done;
   logic [10:0]       res_count;
   logic              err_overflow;

   modport master (
      output host_wr_en, host_addr, host_data, go,
      output output_write_start, output_write_done, com_data_out,
      input  busy, data_write_start, com_data_in, data_write_done,
      input  res_valid, res_index, res_data, run_done, res_count, err_overflow
   );

   modport slave (
      input  host_wr_en, host_addr, host_data, go,
      input  output_write_start, output_write_done, com_data_out,
      output busy, data_write_start, com_data_in, data_write_done,
      output res_valid, res_index, res_data, run_done, res_count, err_overflow
   );
endinterface

// File: rtl/com_host_link.sv
// Host-side link: bursts a pre-loaded buffer into the processor, then captures
// the processor's streamed result words onto an indexed result port.
module com_host_link #(
   parameter int DATA_W     = 16,
   parameter int AW         = 10,
   parameter int LOAD_WORDS = 1024,
   parameter int OUT_MAX    = 1025
) (
   input logic            clk,
   input logic            rst_n,
   com_host_link_if.slave bus
);
   localparam int CW = 11;
   localparam int BW = AW + 1;

   typedef enum logic [2:0] {IDLE, START, DUMMY, BURST, WAIT_OUT, COLLECT, DONE} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] buf_mem [0:(1<<AW)-1];
   logic [DATA_W-1:0] rd_data_reg;
   logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [BW-1:0]     burst_cnt_reg, burst_cnt_next;
   logic [CW-1:0]     count_reg, count_next;
   logic              capture;

   logic              busy_reg, busy_next;
   logic              dws_reg, dws_next;
   logic [DATA_W-1:0] com_data_in_reg, com_data_in_next;
   logic              dwd_reg, dwd_next;
   logic              res_valid_reg, res_valid_next;
   logic [CW-1:0]     res_index_reg, res_index_next;
   logic [DATA_W-1:0] res_data_reg, res_data_next;
   logic              run_done_reg, run_done_next;
   logic [CW-1:0]     res_count_reg, res_count_next;
   logic              err_overflow_reg, err_overflow_next;

   // Read pointer runs two words ahead of the burst: one cycle of RAM latency
   // plus one cycle through the com_data_in output flop.
   always_ff @(posedge clk) begin
      if (bus.host_wr_en && state_reg == IDLE)
         buf_mem[bus.host_addr] <= bus.host_data;
      rd_data_reg <= buf_mem[rd_ptr_reg];
   end

   always_comb begin
      state_next        = state_reg;
      rd_ptr_next       = rd_ptr_reg;
      burst_cnt_next    = burst_cnt_reg;
      count_next        = count_reg;
      capture           = 1'b0;
      dws_next          = 1'b0;
      com_data_in_next  = '0;
      dwd_next          = 1'b0;
      res_valid_next    = 1'b0;
      res_index_next    = res_index_reg;
      res_data_next     = res_data_reg;
      run_done_next     = 1'b0;
      res_count_next    = res_count_reg;
      err_overflow_next = err_overflow_reg;

      case (state_reg)
         IDLE: begin
            rd_ptr_next = '0;
            if (bus.go) begin
               state_next        = START;
               dws_next          = 1'b1;
               count_next        = '0;
               res_count_next    = '0;
               err_overflow_next = 1'b0;
            end
         end
         START: begin
            state_next     = DUMMY;
            rd_ptr_next    = rd_ptr_reg + AW'(1);
            burst_cnt_next = '0;
         end
         DUMMY: begin
            state_next       = BURST;
            rd_ptr_next      = rd_ptr_reg + AW'(1);
            com_data_in_next = rd_data_reg;
            dwd_next         = (LOAD_WORDS == 1);
         end
         BURST: begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
            if (burst_cnt_reg == BW'(LOAD_WORDS - 1)) begin
               state_next = WAIT_OUT;
            end else begin
               burst_cnt_next   = burst_cnt_reg + BW'(1);
               com_data_in_next = rd_data_reg;
               dwd_next         = (burst_cnt_reg + BW'(1) == BW'(LOAD_WORDS - 1));
            end
         end
         WAIT_OUT: begin
            if (bus.output_write_start && !bus.output_write_done) begin
               state_next = COLLECT;
               capture    = 1'b1;
            end
         end
         COLLECT: begin
            // Done wins over a word presented in the same cycle.
            if (bus.output_write_done || !bus.output_write_start) begin
               state_next     = DONE;
               run_done_next  = 1'b1;
               res_count_next = count_reg;
            end else if (count_reg == CW'(OUT_MAX)) begin
               err_overflow_next = 1'b1;
            end else begin
               capture = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      if (capture) begin
         res_valid_next = 1'b1;
         res_data_next  = bus.com_data_out;
         res_index_next = count_reg;
         count_next     = count_reg + CW'(1);
      end

      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         rd_ptr_reg       <= '0;
         burst_cnt_reg    <= '0;
         count_reg        <= '0;
         busy_reg         <= 1'b0;
         dws_reg          <= 1'b0;
         com_data_in_reg  <= '0;
         dwd_reg          <= 1'b0;
         res_valid_reg    <= 1'b0;
         res_index_reg    <= '0;
         res_data_reg     <= '0;
         run_done_reg     <= 1'b0;
         res_count_reg    <= '0;
         err_overflow_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         rd_ptr_reg       <= rd_ptr_next;
         burst_cnt_reg    <= burst_cnt_next;
         count_reg        <= count_next;
         busy_reg         <= busy_next;
         dws_reg          <= dws_next;
         com_data_in_reg  <= com_data_in_next;
         dwd_reg          <= dwd_next;
         res_valid_reg    <= res_valid_next;
         res_index_reg    <= res_index_next;
         res_data_reg     <= res_data_next;
         run_done_reg     <= run_done_next;
         res_count_reg    <= res_count_next;
         err_overflow_reg <= err_overflow_next;
      end
   end

   assign bus.busy             = busy_reg;
   assign bus.data_write_start = dws_reg;
   assign bus.com_data_in      = com_data_in_reg;
   assign bus.data_write_done  = dwd_reg;
   assign bus.res_valid        = res_valid_reg;
   assign bus.res_index        = res_index_reg;
   assign bus.res_data         = res_data_reg;
   assign bus.run_done         = run_done_reg;
   assign bus.res_count        = res_count_reg;
   assign bus.err_overflow     = err_overflow_reg;
endmodule

// File: tb/tb_com_host_link.sv
// Bench for com_host_link: scoreboarded load bursts and result capture, overflow,
// busy-time disturbance, async reset mid-run, and a LOAD_WORDS=1 instance.
module tb_com_host_link;
   localparam int DATA_W  = 16;
   localparam int AW      = 10;
   localparam int LW0     = 4;
   localparam int OUT_MAX = 1025;
   localparam int M_DONE  = 0;
   localparam int M_DROP  = 1;
   localparam int M_NONE  = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   com_host_link_if #(.DATA_W(DATA_W), .AW(AW)) bus ();
   com_host_link_if #(.DATA_W(DATA_W), .AW(AW)) bus1 ();

   com_host_link #(.DATA_W(DATA_W), .AW(AW), .LOAD_WORDS(LW0), .OUT_MAX(OUT_MAX)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   com_host_link #(.DATA_W(DATA_W), .AW(AW), .LOAD_WORDS(1), .OUT_MAX(OUT_MAX)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          run_no = 0;
   int          ld_left = 0;
   int          exp_count = 0;
   bit          exp_ovf = 1'b0;
   logic [15:0] exp_buf [LW0];
   logic [15:0] load_q [$];
   logic [26:0] res_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Load-side scoreboard: start cycle, dummy word, then LW0 buffer words.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.data_write_start) begin
            check("start_word", 64'({bus.data_write_done, bus.com_data_in}), 64'(0));
            ld_left = LW0 + 1;
         end else if (ld_left > 0) begin
            if (load_q.size() == 0) check("load_q_empty", 64'(1), 64'(0));
            else check("load_word", 64'(bus.com_data_in), 64'(load_q.pop_front()));
            check("load_done", 64'(bus.data_write_done), 64'(ld_left == 1));
            ld_left--;
         end else begin
            check("load_idle", 64'({bus.data_write_done, bus.com_data_in}), 64'(0));
         end
      end
   end

   // Result-side scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.res_valid) begin
            if (res_q.size() == 0) check("res_extra", 64'(1), 64'(0));
            else check("res_word", 64'({bus.res_index, bus.res_data}), 64'(res_q.pop_front()));
         end
         if (bus.run_done) begin
            check("res_count", 64'(bus.res_count), 64'(exp_count));
            check("err_overflow", 64'(bus.err_overflow), 64'(exp_ovf));
            check("res_missing", 64'(res_q.size()), 64'(0));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check(tag, 64'({bus.busy, bus.data_write_start, bus.com_data_in, bus.data_write_done,
                      bus.res_valid, bus.res_index, bus.res_data, bus.run_done,
                      bus.res_count, bus.err_overflow}), 64'(0));
   endtask

   task automatic start_go();
      @(negedge clk);
      bus.go = 1'b1;
      load_q.push_back(16'h0000);
      for (int i = 0; i < LW0; i++) load_q.push_back(exp_buf[i]);
      @(negedge clk);
      bus.go = 1'b0;
      bus.output_write_start = 1'b0;
   endtask

   task automatic wait_load_end();
      int i = 0;
      while (!(ld_left == 0 && load_q.size() == 0) && i < 50) begin
         @(negedge clk);
         i++;
      end
      if (i >= 50) check("load_timeout", 64'(1), 64'(0));
   endtask

   task automatic wait_run_done();
      int i = 0;
      while (!bus.run_done && i < 100) begin
         @(negedge clk);
         i++;
      end
      if (i >= 100) check("run_done_timeout", 64'(1), 64'(0));
   endtask

   task automatic stream(input int n, input int mode, input bit rnd);
      logic [15:0] d;
      exp_count = (n < OUT_MAX) ? n : OUT_MAX;
      exp_ovf   = (n > OUT_MAX);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         d = rnd ? 16'($urandom_range(0, 65535)) : 16'(i);
         bus.output_write_start = 1'b1;
         bus.output_write_done  = 1'b0;
         bus.com_data_out       = d;
         if (i < OUT_MAX) res_q.push_back({11'(i), d});
      end
      if (mode == M_DONE) begin
         @(negedge clk);
         bus.output_write_done = 1'b1;
         bus.com_data_out      = 16'hDEAD;
         @(negedge clk);
         bus.output_write_done = 1'b0;
      end else if (mode == M_DROP) begin
         @(negedge clk);
         bus.output_write_start = 1'b0;
      end
   endtask

   task automatic run(input int n, input int mode, input bit rnd, input bit disturb);
      start_go();
      check("busy_start", 64'(bus.busy), 64'(1));
      check("ovf_cleared", 64'(bus.err_overflow), 64'(0));
      check("count_cleared", 64'(bus.res_count), 64'(0));
      if (disturb) begin
         bus.host_wr_en = 1'b1;
         bus.go         = 1'b1;
         for (int i = 0; i < 6; i++) begin
            bus.host_addr = AW'(i % LW0);
            bus.host_data = 16'hBEE0 + 16'(i);
            @(negedge clk);
         end
         bus.host_wr_en = 1'b0;
         bus.go         = 1'b0;
      end
      wait_load_end();
      tick(2);
      stream(n, mode, rnd);
      wait_run_done();
      tick(1);
      check("idle_after_run", 64'(bus.busy), 64'(0));
      run_no++;
      $display("run %0d: streamed=%0d expect_count=%0d expect_ovf=%0d res_count=%0d ovf=%0d",
               run_no, n, exp_count, exp_ovf, bus.res_count, bus.err_overflow);
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      load_q.delete();
      res_q.delete();
      ld_left = 0;
      bus.output_write_start = 1'b0;
      bus.output_write_done  = 1'b0;
      bus.go                 = 1'b0;
      bus.host_wr_en         = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      $display("async reset applied at %0t", $time);
   endtask

   initial begin
      bus.host_wr_en = 0; bus.host_addr = '0; bus.host_data = '0; bus.go = 0;
      bus.output_write_start = 0; bus.output_write_done = 0; bus.com_data_out = '0;
      bus1.host_wr_en = 0; bus1.host_addr = '0; bus1.host_data = '0; bus1.go = 0;
      bus1.output_write_start = 0; bus1.output_write_done = 0; bus1.com_data_out = '0;
      for (int i = 0; i < LW0; i++) exp_buf[i] = 16'hA001 + 16'(i);

      tick(2);
      check_zero("reset_state");
      rst_n = 1'b1;
      tick(1);

      for (int i = 0; i < LW0; i++) begin
         @(negedge clk);
         bus.host_wr_en = 1'b1;
         bus.host_addr  = AW'(i);
         bus.host_data  = exp_buf[i];
      end
      @(negedge clk);
      bus.host_wr_en = 1'b0;

      run(1025, M_DONE, 1'b0, 1'b0);
      run(1030, M_DONE, 1'b0, 1'b0);
      tick(3);
      check("ovf_sticky", 64'(bus.err_overflow), 64'(1));
      check("count_held", 64'(bus.res_count), 64'(1025));
      run(7, M_DROP, 1'b1, 1'b1);
      run(12, M_DONE, 1'b1, 1'b0);

      start_go();
      tick(3);
      async_reset();
      run(9, M_DONE, 1'b1, 1'b0);

      start_go();
      wait_load_end();
      tick(2);
      stream(20, M_NONE, 1'b1);
      async_reset();
      run(1025, M_DONE, 1'b0, 1'b0);

      // Single-word burst on the second instance.
      @(negedge clk);
      bus1.host_wr_en = 1'b1;
      bus1.host_addr  = '0;
      bus1.host_data  = 16'h5A5A;
      @(negedge clk);
      bus1.host_wr_en = 1'b0;
      bus1.go         = 1'b1;
      @(negedge clk);
      bus1.go = 1'b0;
      check("lw1_start", 64'({bus1.data_write_start, bus1.data_write_done, bus1.com_data_in}), 64'({1'b1, 1'b0, 16'h0000}));
      @(negedge clk);
      check("lw1_dummy", 64'({bus1.data_write_start, bus1.data_write_done, bus1.com_data_in}), 64'(0));
      @(negedge clk);
      check("lw1_word", 64'({bus1.data_write_start, bus1.data_write_done, bus1.com_data_in}), 64'({1'b0, 1'b1, 16'h5A5A}));
      @(negedge clk);
      check("lw1_after", 64'({bus1.data_write_start, bus1.data_write_done, bus1.com_data_in}), 64'(0));
      @(negedge clk);
      bus1.output_write_start = 1'b1;
      bus1.com_data_out       = 16'h0011;
      @(negedge clk);
      bus1.com_data_out = 16'h0022;
      check("lw1_res0", 64'({bus1.res_valid, bus1.res_index, bus1.res_data}), 64'({1'b1, 11'd0, 16'h0011}));
      @(negedge clk);
      bus1.output_write_done = 1'b1;
      check("lw1_res1", 64'({bus1.res_valid, bus1.res_index, bus1.res_data}), 64'({1'b1, 11'd1, 16'h0022}));
      @(negedge clk);
      bus1.output_write_done = 1'b0;
      check("lw1_done", 64'({bus1.res_valid, bus1.run_done, bus1.res_count}), 64'({1'b0, 1'b1, 11'd2}));
      $display("lw1 run: res_count=%0d", bus1.res_count);
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/com_host_link.md
Name: com_host_link

Overview:
- Host-side counterpart of the processor top-level communication interface.
- Host software pre-loads a local input buffer, then pulses `go`.
- The block drives the processor load handshake (`data_write_start` / `com_data_in` / `data_write_done`) as a back-to-back, non-stallable word burst.
- It then waits for the processor's output phase and captures every streamed result word (`com_data_out` while `output_write_start` is high and `output_write_done` is low) onto an indexed result port.

Parameters:
- DATA_W, 16: word width of the buffer, the processor data ports and the result port.
- AW, 10: input buffer address width; buffer depth is 2^AW.
- LOAD_WORDS, 1024: words sent per burst; legal range 1..2^AW.
- OUT_MAX, 1025: maximum result words captured per run.

Ports:
- `clk` in 1: single clock, all state updated on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `host_wr_en` in 1: write strobe into the input buffer.
- `host_addr` in AW: input buffer write address.
- `host_data` in DATA_W: input buffer write data.
- `go` in 1: start a run; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `data_write_start` out 1: one-cycle load-start pulse to the processor.
- `com_data_in` out DATA_W: load word to the processor.
- `data_write_done` out 1: one-cycle pulse marking the last load word.
- `output_write_start` in 1: processor output phase active (level).
- `output_write_done` in 1: processor output phase finished (one-cycle pulse).
- `com_data_out` in DATA_W: processor result word.
- `res_valid` out 1: result word valid this cycle (no backpressure).
- `res_index` out 11: result word index, 0-based.
- `res_data` out DATA_W: result word.
- `run_done` out 1: one-cycle pulse at end of run.
- `res_count` out 11: words captured in the last run; held until the next `go`.
- `err_overflow` out 1: sticky; cleared on accepted `go`.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE; all outputs 0 (`res_count`=0, `err_overflow`=0). Input buffer contents are not reset.
- Buffer writes: accepted only in IDLE; ignored while `busy`=1.
- Every output is a registered flop; no combinational input-to-output paths.

States:
- IDLE:
  - `go`=1 → START.
  - Clear `res_count`, clear `err_overflow`, reset read pointer to 0.
  - `go` in any other state is ignored.
- START:
  - Drive `data_write_start`=1 for exactly this cycle; `com_data_in`=0.
  - → DUMMY.
- DUMMY:
  - Drive `com_data_in`=0. The processor writes this word to address 0xFFFF; it is a discard word.
  - → BURST.
- BURST:
  - Cycle k of BURST (k = 0..LOAD_WORDS-1) drives `com_data_in` = buf[k].
  - The processor lands buf[k] at its address k.
  - No gaps are permitted; the processor cannot stall.
  - `data_write_done`=1 only in the cycle carrying buf[LOAD_WORDS-1] (for LOAD_WORDS=1, the first BURST cycle).
  - After the last word → WAIT_OUT with `com_data_in`=0.
- WAIT_OUT:
  - `output_write_start`=1 and `output_write_done`=0 → COLLECT, capturing that cycle's word as index 0.
  - No timeout.
- COLLECT: each cycle with `output_write_start`=1 and `output_write_done`=0:
  - Register `res_valid`=1, `res_data`=`com_data_out`, `res_index`=count; count++.
  - Result port latency is 1 cycle from sample to `res_valid`.
- End of COLLECT:
  - `output_write_done`=1 → DONE. The word on `com_data_out` that cycle is not captured.
  - `output_write_start` falling without done → DONE.
- Overflow: count reaching OUT_MAX while still collecting sets `err_overflow`=1 and suppresses further capture. State remains COLLECT until done.
- DONE:
  - `run_done`=1 for one cycle; `res_count`=count.
  - → IDLE.
- `output_write_start` stays high after a run until the processor's next load. WAIT_OUT is entered only after a fresh burst, so the stale level is harmless: by then the processor has cleared it.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. The processor side is recovered by the system reset.

Test Plan:
- Load 4 words (0xA001..0xA004), LOAD_WORDS=4, pulse `go`:
  - `data_write_start` for 1 cycle, then 0x0000, then A001, A002, A003, A004 on consecutive cycles.
  - `data_write_done` high only with A004.
- Processor model asserts `output_write_start` and streams 0x0000..0x0400, then pulses `output_write_done`:
  - 1025 `res_valid` pulses with `res_index` 0..1024 and `res_data` equal to `res_index`.
  - `run_done` once; `res_count`=1025.
- Stream 1030 words with OUT_MAX=1025:
  - Captures stop at index 1024; `err_overflow`=1 until the next `go`.
- `host_wr_en` and `go` asserted during BURST:
  - Buffer unchanged; no restart; the burst sequence is identical to the idle-load case.
- Deassert `rst_n` in mid-BURST, then in mid-COLLECT:
  - All outputs 0 asynchronously; state IDLE.
  - A following `go` runs a full, correct sequence.
- LOAD_WORDS=1:
  - `data_write_start`, dummy word, then a single word with `data_write_done` high in the same cycle.
